// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared types and defaults for the edge frame sequencer
package edge_pkg;

  localparam int PIX_W      = 8;
  localparam int MAX_W_DEF  = 50;
  localparam int HBLANK_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LINE,
    BLANK,
    FLUSH,
    DONE
  } stateT;

endpackage

// File: rtl/edge_writeback.sv
// rtl/edge_writeback.sv - captures the returned edge stream into the result memory
module edge_writeback
  import edge_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Enable,
  input  logic              Clear,
  input  logic [PIX_W-1:0]  EdgePixel,
  input  logic              EdgeFrame,
  input  logic              EdgeLine,
  input  logic [7:0]        Width,
  input  logic [7:0]        Height,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [PIX_W-1:0]  WrData,
  output logic              FrameComplete
);

  logic              capActive;
  logic [7:0]        capCol;
  logic [7:0]        lineCnt;
  logic [ADDR_W-1:0] addrCnt;

  logic              capture;
  logic [7:0]        colNow;
  logic [7:0]        lineBase;
  logic [7:0]        lineNow;
  logic [ADDR_W-1:0] addrNow;
  logic              lastCol;

  // A line strobe always opens a fresh capture, even on top of one in flight.
  assign capture  = Enable && (EdgeLine || capActive);
  assign colNow   = EdgeLine ? 8'd0 : capCol;
  assign lineBase = EdgeFrame ? 8'd0 : lineCnt;
  assign lineNow  = EdgeLine ? lineBase + 8'd1 : lineBase;
  assign addrNow  = EdgeFrame ? '0 : addrCnt;
  assign lastCol  = (colNow == Width - 8'd1);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      capActive     <= 1'b0;
      capCol        <= 8'd0;
      lineCnt       <= 8'd0;
      addrCnt       <= '0;
      WrEn          <= 1'b0;
      WrAddr        <= '0;
      WrData        <= '0;
      FrameComplete <= 1'b0;
    end else if (Clear) begin
      capActive     <= 1'b0;
      capCol        <= 8'd0;
      lineCnt       <= 8'd0;
      addrCnt       <= '0;
      WrEn          <= 1'b0;
      FrameComplete <= 1'b0;
    end else if (!Enable) begin
      capActive <= 1'b0;
      WrEn      <= 1'b0;
    end else begin
      WrEn <= capture;
      if (capture) begin
        WrData    <= EdgePixel;
        WrAddr    <= addrNow;
        addrCnt   <= addrNow + ADDR_W'(1);
        lineCnt   <= lineNow;
        capCol    <= colNow + 8'd1;
        capActive <= !lastCol;
        if (lastCol && (lineNow == Height)) begin
          FrameComplete <= 1'b1;
        end
      end else if (EdgeFrame) begin
        addrCnt <= '0;
        lineCnt <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/edge_frame_ctrl.sv
// rtl/edge_frame_ctrl.sv - frame sequencer feeding the edge stage and collecting its output
module edge_frame_ctrl
  import edge_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int MAX_W  = MAX_W_DEF,
  parameter int HBLANK = HBLANK_DEF
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Start,
  input  logic [7:0]        Width,
  input  logic [7:0]        Height,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic              RdEn,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [PIX_W-1:0]  RdData,
  output logic [PIX_W-1:0]  PixelOut,
  output logic              FrameOut,
  output logic              LineOut,
  output logic [7:0]        StrideOut,
  input  logic [PIX_W-1:0]  EdgePixel,
  input  logic              EdgeFrame,
  input  logic              EdgeLine,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [PIX_W-1:0]  WrData
);

  localparam logic [3:0] BLANK_LAST = 4'(HBLANK - 1);
  localparam logic [8:0] MAX_STRIDE = 9'(MAX_W);

  stateT      state;
  logic [7:0] widthQ;
  logic [7:0] heightQ;
  logic [7:0] colCnt;
  logic [7:0] lineCnt;
  logic [3:0] blankCnt;
  logic       rdEnD;
  logic       frameComplete;

  logic [8:0] startStride;
  logic       startOk;

  assign startStride = {1'b0, Width} + 9'(HBLANK);
  assign startOk     = (Width != 8'd0) && (Height != 8'd0) && (startStride <= MAX_STRIDE);

  // Memory data arrives a cycle after the strobe, so the pixel path is gated by the delayed strobe.
  assign PixelOut = rdEnD ? RdData : '0;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      widthQ    <= 8'd0;
      heightQ   <= 8'd0;
      colCnt    <= 8'd0;
      lineCnt   <= 8'd0;
      blankCnt  <= 4'd0;
      rdEnD     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      RdEn      <= 1'b0;
      RdAddr    <= '0;
      FrameOut  <= 1'b0;
      LineOut   <= 1'b0;
      StrideOut <= 8'd0;
    end else begin
      Error    <= 1'b0;
      Done     <= 1'b0;
      rdEnD    <= RdEn;
      FrameOut <= RdEn && (colCnt == 8'd0) && (lineCnt == 8'd0);
      LineOut  <= RdEn && (colCnt == 8'd0);
      case (state)
        IDLE: begin
          if (Start) begin
            if (startOk) begin
              widthQ  <= Width;
              heightQ <= Height;
              Busy    <= 1'b1;
              state   <= LOAD;
            end else begin
              Error <= 1'b1;
            end
          end
        end
        LOAD: begin
          StrideOut <= widthQ + 8'(HBLANK);
          RdAddr    <= '0;
          colCnt    <= 8'd0;
          lineCnt   <= 8'd0;
          blankCnt  <= 4'd0;
          RdEn      <= 1'b1;
          state     <= LINE;
        end
        LINE: begin
          RdAddr <= RdAddr + ADDR_W'(1);
          if (colCnt == widthQ - 8'd1) begin
            RdEn     <= 1'b0;
            colCnt   <= 8'd0;
            blankCnt <= 4'd0;
            lineCnt  <= lineCnt + 8'd1;
            state    <= BLANK;
          end else begin
            colCnt <= colCnt + 8'd1;
          end
        end
        BLANK: begin
          if (blankCnt == BLANK_LAST) begin
            if (lineCnt == heightQ) begin
              state <= FLUSH;
            end else begin
              RdEn  <= 1'b1;
              state <= LINE;
            end
          end else begin
            blankCnt <= blankCnt + 4'd1;
          end
        end
        FLUSH: begin
          if (frameComplete) begin
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  edge_writeback #(
    .ADDR_W(ADDR_W)
  ) uWriteback (
    .Clk          (Clk),
    .nReset       (nReset),
    .Enable       (state != IDLE),
    .Clear        (state == LOAD),
    .EdgePixel    (EdgePixel),
    .EdgeFrame    (EdgeFrame),
    .EdgeLine     (EdgeLine),
    .Width        (widthQ),
    .Height       (heightQ),
    .WrEn         (WrEn),
    .WrAddr       (WrAddr),
    .WrData       (WrData),
    .FrameComplete(frameComplete)
  );

endmodule
